pht_upd_ctrl: RTL

Update controller for the set-indexed pattern history table. Accepts branch-resolution events from the execute stage, buffers them, performs a read-modify-write of the addressed 2-bit saturating counter through the table's single shared address port, and drives the table's write enable and update data. Sits directly upstream of the PHT write side and arbitrates for the address port against the prediction lookup path, which has priority.

---
 rtl/pht_upd_ctrl_pkg.sv | 16 +
 rtl/pht_upd_fifo.sv | 49 ++++
 rtl/pht_upd_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/pht_upd_ctrl_pkg.sv
// Shared definitions for the PHT update controller: table widths and FSM encodings.
// The table and the controller both take their widths from here so they cannot drift apart.
package pht_upd_ctrl_pkg;

    localparam int PHT_SET_W      = 2;
    localparam int PHT_IDX_W      = 10;
    localparam int PHT_CNT_W      = 2;
    localparam int PHT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } upd_state_t;

endpackage

// File: rtl/pht_upd_fifo.sv
// Resolution-event queue: synchronous show-ahead FIFO with an extra pointer bit
// so that full and empty can be told apart without a separate occupancy counter.
module pht_upd_fifo
    import pht_upd_ctrl_pkg::*;
#(
    parameter int WIDTH = PHT_SET_W + PHT_IDX_W + 1,
    parameter int DEPTH = PHT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/pht_upd_ctrl.sv
// PHT update controller: queues branch resolutions and performs a read-modify-write
// of the addressed 2-bit saturating counter through the shared table port.
module pht_upd_ctrl
    import pht_upd_ctrl_pkg::*;
#(
    parameter int SET_W      = PHT_SET_W,
    parameter int IDX_W      = PHT_IDX_W,
    parameter int CNT_W      = PHT_CNT_W,
    parameter int FIFO_DEPTH = PHT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [SET_W-1:0] res_set,
    input  logic [IDX_W-1:0] res_idx,
    input  logic             res_taken,
    output logic             pht_req,
    input  logic             pht_gnt,
    output logic [SET_W-1:0] pht_set,
    output logic [IDX_W-1:0] pht_idx,
    input  logic [CNT_W-1:0] pht_rd_data,
    output logic             pht_wr_en,
    output logic [CNT_W-1:0] pht_up_data,
    output logic             busy
);

    localparam int ENT_W = SET_W + IDX_W + 1;

    upd_state_t       state;
    logic [SET_W-1:0] wk_set;
    logic [IDX_W-1:0] wk_idx;
    logic             wk_taken;
    logic [CNT_W-1:0] up_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [ENT_W-1:0] fifo_rd;
    logic [SET_W-1:0] ent_set;
    logic [IDX_W-1:0] ent_idx;
    logic             ent_taken;

    function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] cnt,
                                                    input logic             taken);
        logic [CNT_W-1:0] max_cnt;
        max_cnt = '1;
        if (taken) return (cnt == max_cnt) ? cnt : cnt + 1'b1;
        else       return (cnt == '0)      ? cnt : cnt - 1'b1;
    endfunction

    pht_upd_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (res_valid),
        .push_data ({res_set, res_idx, res_taken}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {ent_set, ent_idx, ent_taken} = fifo_rd;

    // A new event is loaded from IDLE, or straight out of a completed WRITE.
    assign fifo_pop = !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_WRITE) && pht_gnt));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wk_set   <= '0;
            wk_idx   <= '0;
            wk_taken <= 1'b0;
            up_reg   <= '0;
        end else begin
            if (fifo_pop) begin
                wk_set   <= ent_set;
                wk_idx   <= ent_idx;
                wk_taken <= ent_taken;
            end
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) state <= ST_READ;
                end
                ST_READ: begin
                    if (pht_gnt) begin
                        up_reg <= sat_update(pht_rd_data, wk_taken);
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (pht_gnt) state <= fifo_empty ? ST_IDLE : ST_READ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign res_ready   = !fifo_full;
    assign pht_req     = (state != ST_IDLE);
    assign pht_set     = wk_set;
    assign pht_idx     = wk_idx;
    assign pht_wr_en   = (state == ST_WRITE) && pht_gnt;
    assign pht_up_data = up_reg;
    assign busy        = (state != ST_IDLE) || !fifo_empty;

endmodule
